trap_ctrl: RTL and testbench

//  Machine-mode trap initiator driving the CSR file's trap/mret interface. Watches the

---
 rtl/trap_ctrl_pkg.sv | 24 ++
 rtl/trap_ctrl_if.sv | 43 ++++
 rtl/trap_ctrl_int_sync.sv | 29 ++
 rtl/trap_ctrl.sv | 152 +++++++++++++++
 tb/tb_trap_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap controller: mcause codes,
// mtvec mode encodings and the trap FSM state type.
package trap_ctrl_pkg;

    localparam logic [31:0] CAUSE_ILLEGAL  = 32'd2;
    localparam logic [31:0] CAUSE_BREAK    = 32'd3;
    localparam logic [31:0] CAUSE_LD_FAULT = 32'd5;
    localparam logic [31:0] CAUSE_ST_FAULT = 32'd7;
    localparam logic [31:0] CAUSE_ECALL_M  = 32'd11;

    localparam logic [31:0] EXT_CAUSE_DEFAULT = 32'h8000_000B;

    localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
    localparam logic [1:0] MTVEC_VECTORED = 2'd1;

    localparam int MSTATUS_MIE = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TRAP = 2'd1,
        RET  = 2'd2
    } trap_state_t;

endpackage

// File: rtl/trap_ctrl_if.sv
// MEM-stage, CSR-file and PC-mux signals seen by the trap controller.
// master is the controller's view, slave is the surrounding pipeline's view.
interface trap_ctrl_if;

    logic        mem_valid;
    logic [31:0] mem_pc;
    logic [31:0] mem_inst;
    logic [31:0] mem_addr;
    logic        exc_illegal;
    logic        exc_ecall;
    logic        exc_ebreak;
    logic        exc_ld_fault;
    logic        exc_st_fault;
    logic        mem_mret;
    logic        ext_int;
    logic [31:0] mstatus;
    logic [31:0] mtvec;
    logic [31:0] mepc_i;

    logic        is_trap;
    logic        is_mret;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;

    modport master (
        input  mem_valid, mem_pc, mem_inst, mem_addr,
        input  exc_illegal, exc_ecall, exc_ebreak, exc_ld_fault, exc_st_fault,
        input  mem_mret, ext_int, mstatus, mtvec, mepc_i,
        output is_trap, is_mret, mepc, mcause, mtval, redirect, redirect_pc, flush
    );

    modport slave (
        output mem_valid, mem_pc, mem_inst, mem_addr,
        output exc_illegal, exc_ecall, exc_ebreak, exc_ld_fault, exc_st_fault,
        output mem_mret, ext_int, mstatus, mtvec, mepc_i,
        input  is_trap, is_mret, mepc, mcause, mtval, redirect, redirect_pc, flush
    );

endinterface

// File: rtl/trap_ctrl_int_sync.sv
// External-interrupt synchroniser: SYNC_STAGES flop chain followed by a
// rising-edge detector on the synchronised level.
module int_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // NOTE: sequential state uses non-blocking assignments so every flop in the
    // chain samples its predecessor's pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap initiator: prioritises MEM-stage exceptions and a latched
// external interrupt, pulses trap/mret to the CSR file and redirects fetch.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [31:0] EXT_CAUSE   = EXT_CAUSE_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    trap_ctrl_if.master   bus
);

    trap_state_t state;

    logic        int_rise;
    logic        int_pend;
    logic        pend_eff;
    logic        take_int;
    logic        decide;
    logic        trap_dec;
    logic        do_trap;
    logic        do_ret;
    logic        int_taken;
    logic [31:0] cause;
    logic [31:0] tval;
    logic [31:0] trap_pc;

    logic [31:0] last_cause;
    logic [31:0] last_tval;

    logic        is_trap_q;
    logic        is_mret_q;
    logic        redirect_q;
    logic        flush_q;
    logic [31:0] redirect_pc_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic [31:0] mtval_q;

    logic        unused_bits;

    int_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_int_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (bus.ext_int),
        .rise     (int_rise)
    );

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        pend_eff  = int_pend | int_rise;
        take_int  = pend_eff & bus.mstatus[MSTATUS_MIE];
        decide    = (state == IDLE) && bus.mem_valid;
        trap_dec  = 1'b1;
        cause     = '0;
        tval      = '0;
        if (take_int) begin
            cause = EXT_CAUSE;
        end else if (bus.exc_illegal) begin
            cause = CAUSE_ILLEGAL;
            tval  = bus.mem_inst;
        end else if (bus.exc_ebreak) begin
            cause = CAUSE_BREAK;
            tval  = bus.mem_pc;
        end else if (bus.exc_ecall) begin
            cause = CAUSE_ECALL_M;
        end else if (bus.exc_ld_fault) begin
            cause = CAUSE_LD_FAULT;
            tval  = bus.mem_addr;
        end else if (bus.exc_st_fault) begin
            cause = CAUSE_ST_FAULT;
            tval  = bus.mem_addr;
        end else begin
            trap_dec = 1'b0;
        end
        do_trap   = decide & trap_dec;
        do_ret    = decide & ~trap_dec & bus.mem_mret;
        int_taken = decide & take_int;

        // Only interrupts are vectored; exceptions always land on the base.
        trap_pc = {bus.mtvec[31:2], 2'b00};
        if (bus.mtvec[1:0] == MTVEC_VECTORED && cause[31])
            trap_pc = trap_pc + {cause[29:0], 2'b00};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            int_pend      <= 1'b0;
            last_cause    <= '0;
            last_tval     <= '0;
            is_trap_q     <= 1'b0;
            is_mret_q     <= 1'b0;
            redirect_q    <= 1'b0;
            flush_q       <= 1'b0;
            redirect_pc_q <= '0;
            mepc_q        <= '0;
            mcause_q      <= '0;
            mtval_q       <= '0;
        end else begin
            // A rise coinciding with the take is absorbed by that same take.
            int_pend   <= int_taken ? 1'b0 : pend_eff;
            is_trap_q  <= 1'b0;
            is_mret_q  <= 1'b0;
            redirect_q <= 1'b0;
            flush_q    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (do_trap) begin
                        state         <= TRAP;
                        is_trap_q     <= 1'b1;
                        redirect_q    <= 1'b1;
                        flush_q       <= 1'b1;
                        redirect_pc_q <= trap_pc;
                        mepc_q        <= bus.mem_pc;
                        mcause_q      <= cause;
                        mtval_q       <= tval;
                        last_cause    <= cause;
                        last_tval     <= tval;
                    end else if (do_ret) begin
                        state         <= RET;
                        is_mret_q     <= 1'b1;
                        redirect_q    <= 1'b1;
                        flush_q       <= 1'b1;
                        redirect_pc_q <= bus.mepc_i;
                        mepc_q        <= bus.mepc_i;
                        mcause_q      <= last_cause;
                        mtval_q       <= last_tval;
                    end
                end
                TRAP, RET: state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

    assign bus.is_trap     = is_trap_q;
    assign bus.is_mret     = is_mret_q;
    assign bus.redirect    = redirect_q;
    assign bus.redirect_pc = redirect_pc_q;
    assign bus.mepc        = mepc_q;
    assign bus.mcause      = mcause_q;
    assign bus.mtval       = mtval_q;
    // The decide-cycle term is gated by reset so flush drops the moment rst_n falls.
    assign bus.flush       = flush_q | ((do_trap | do_ret) & rst_n);

    assign unused_bits = ^{bus.mstatus[31:4], bus.mstatus[2:0], cause[30]};

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: a directed vector table for the
// exception/mret paths plus hand-written interrupt and reset sequences.
module tb_trap_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    trap_ctrl_if bus ();

    trap_ctrl #(
        .SYNC_STAGES (2),
        .EXT_CAUSE   (32'h8000_000B)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [4:0] EX_NONE = 5'b00000;
    localparam logic [4:0] EX_ILL  = 5'b10000;
    localparam logic [4:0] EX_BRK  = 5'b01000;
    localparam logic [4:0] EX_ECL  = 5'b00100;
    localparam logic [4:0] EX_LD   = 5'b00010;
    localparam logic [4:0] EX_ST   = 5'b00001;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] addr;
        logic [4:0]  exc;
        logic        mret;
        logic [31:0] mtvec;
        logic [31:0] mepc_i;
        logic        e_trap;
        logic        e_mret;
        logic        e_redir;
        logic        e_flush;
        logic [31:0] e_rpc;
        logic [31:0] e_mepc;
        logic [31:0] e_mcause;
        logic [31:0] e_mtval;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    function automatic vec_t mk(
        input logic valid, input logic [31:0] pc, input logic [31:0] inst,
        input logic [31:0] addr, input logic [4:0] exc, input logic mret,
        input logic [31:0] mtvec, input logic [31:0] mepc_i,
        input logic e_trap, input logic e_mret, input logic e_redir, input logic e_flush,
        input logic [31:0] e_rpc, input logic [31:0] e_mepc,
        input logic [31:0] e_mcause, input logic [31:0] e_mtval);
        vec_t v;
        v.valid = valid;   v.pc = pc;         v.inst = inst;       v.addr = addr;
        v.exc = exc;       v.mret = mret;     v.mtvec = mtvec;     v.mepc_i = mepc_i;
        v.e_trap = e_trap; v.e_mret = e_mret; v.e_redir = e_redir; v.e_flush = e_flush;
        v.e_rpc = e_rpc;   v.e_mepc = e_mepc; v.e_mcause = e_mcause; v.e_mtval = e_mtval;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.mem_valid    = v.valid;
        bus.mem_pc       = v.pc;
        bus.mem_inst     = v.inst;
        bus.mem_addr     = v.addr;
        bus.exc_illegal  = v.exc[4];
        bus.exc_ebreak   = v.exc[3];
        bus.exc_ecall    = v.exc[2];
        bus.exc_ld_fault = v.exc[1];
        bus.exc_st_fault = v.exc[0];
        bus.mem_mret     = v.mret;
        bus.mtvec        = v.mtvec;
        bus.mepc_i       = v.mepc_i;
    endtask

    task automatic plain(input logic valid, input logic [31:0] pc);
        bus.mem_valid    = valid;
        bus.mem_pc       = pc;
        bus.mem_inst     = 32'h0000_0013;
        bus.mem_addr     = '0;
        bus.exc_illegal  = 1'b0;
        bus.exc_ebreak   = 1'b0;
        bus.exc_ecall    = 1'b0;
        bus.exc_ld_fault = 1'b0;
        bus.exc_st_fault = 1'b0;
        bus.mem_mret     = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts trap pulses over n cycles while inputs stay as they are.
    task automatic count_traps(input int n, output int pulses);
        pulses = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (bus.is_trap) pulses++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int pulses;
        logic got;

        checks = 0;
        errors = 0;

        vecs[0]  = mk(0, 32'h000, 32'h0,        32'h0,    EX_NONE,       0, 32'h200, 32'h000, 0,0,0,0, 32'h000, 32'h000, 32'd0,  32'h0);
        vecs[1]  = mk(1, 32'h100, 32'h13,       32'h0,    EX_ECL,        0, 32'h200, 32'h000, 0,0,0,1, 32'h000, 32'h000, 32'd0,  32'h0);
        vecs[2]  = mk(1, 32'h104, 32'h13,       32'h0,    EX_ECL,        0, 32'h200, 32'h000, 1,0,1,1, 32'h200, 32'h100, 32'd11, 32'h0);
        vecs[3]  = mk(0, 32'h000, 32'h0,        32'h0,    EX_NONE,       0, 32'h200, 32'h000, 0,0,0,0, 32'h200, 32'h100, 32'd11, 32'h0);
        vecs[4]  = mk(0, 32'h108, 32'h0,        32'h0,    EX_ECL,        0, 32'h200, 32'h000, 0,0,0,0, 32'h200, 32'h100, 32'd11, 32'h0);
        vecs[5]  = mk(1, 32'h104, 32'h0,        32'h0,    EX_NONE,       1, 32'h200, 32'h104, 0,0,0,1, 32'h200, 32'h100, 32'd11, 32'h0);
        vecs[6]  = mk(0, 32'h000, 32'h0,        32'h0,    EX_NONE,       0, 32'h200, 32'h104, 0,1,1,1, 32'h104, 32'h104, 32'd11, 32'h0);
        vecs[7]  = mk(1, 32'h108, 32'hFFFFFFFF, 32'h40,   EX_ILL|EX_LD,  0, 32'h200, 32'h000, 0,0,0,1, 32'h104, 32'h104, 32'd11, 32'h0);
        vecs[8]  = mk(0, 32'h000, 32'h0,        32'h0,    EX_NONE,       0, 32'h200, 32'h000, 1,0,1,1, 32'h200, 32'h108, 32'd2,  32'hFFFFFFFF);
        vecs[9]  = mk(0, 32'h000, 32'h0,        32'h0,    EX_NONE,       0, 32'h200, 32'h000, 0,0,0,0, 32'h200, 32'h108, 32'd2,  32'hFFFFFFFF);
        vecs[10] = mk(1, 32'h10C, 32'h0,        32'h0,    EX_BRK,        0, 32'h200, 32'h000, 0,0,0,1, 32'h200, 32'h108, 32'd2,  32'hFFFFFFFF);
        vecs[11] = mk(0, 32'h000, 32'h0,        32'h0,    EX_NONE,       0, 32'h200, 32'h000, 1,0,1,1, 32'h200, 32'h10C, 32'd3,  32'h10C);
        vecs[12] = mk(1, 32'h110, 32'h0,        32'h2000, EX_ST,         1, 32'h200, 32'h000, 0,0,0,1, 32'h200, 32'h10C, 32'd3,  32'h10C);
        vecs[13] = mk(0, 32'h000, 32'h0,        32'h0,    EX_NONE,       0, 32'h200, 32'h000, 1,0,1,1, 32'h200, 32'h110, 32'd7,  32'h2000);
        vecs[14] = mk(1, 32'h114, 32'h0,        32'h3000, EX_LD,         0, 32'h201, 32'h000, 0,0,0,1, 32'h200, 32'h110, 32'd7,  32'h2000);
        vecs[15] = mk(0, 32'h000, 32'h0,        32'h0,    EX_NONE,       0, 32'h201, 32'h000, 1,0,1,1, 32'h200, 32'h114, 32'd5,  32'h3000);
        vecs[16] = mk(1, 32'h118, 32'h0,        32'h0,    EX_NONE,       1, 32'h201, 32'h118, 0,0,0,1, 32'h200, 32'h114, 32'd5,  32'h3000);
        vecs[17] = mk(0, 32'h000, 32'h0,        32'h0,    EX_NONE,       0, 32'h201, 32'h118, 0,1,1,1, 32'h118, 32'h118, 32'd5,  32'h3000);
        vecs[18] = mk(0, 32'h000, 32'h0,        32'h0,    EX_NONE,       0, 32'h201, 32'h118, 0,0,0,0, 32'h118, 32'h118, 32'd5,  32'h3000);

        rst_n       = 1'b0;
        bus.ext_int = 1'b0;
        bus.mstatus = 32'h0;
        drive(vecs[0]);
        #12;
        rst_n = 1'b1;

        // Each row: inputs held for one cycle, outputs sampled late in that cycle.
        for (int i = 0; i < NVEC; i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            #3;
            check($sformatf("v%0d_is_trap", i),     {31'b0, bus.is_trap},  {31'b0, vecs[i].e_trap});
            check($sformatf("v%0d_is_mret", i),     {31'b0, bus.is_mret},  {31'b0, vecs[i].e_mret});
            check($sformatf("v%0d_redirect", i),    {31'b0, bus.redirect}, {31'b0, vecs[i].e_redir});
            check($sformatf("v%0d_flush", i),       {31'b0, bus.flush},    {31'b0, vecs[i].e_flush});
            check($sformatf("v%0d_redirect_pc", i), bus.redirect_pc, vecs[i].e_rpc);
            check($sformatf("v%0d_mepc", i),        bus.mepc,        vecs[i].e_mepc);
            check($sformatf("v%0d_mcause", i),      bus.mcause,      vecs[i].e_mcause);
            check($sformatf("v%0d_mtval", i),       bus.mtval,       vecs[i].e_mtval);
        end

        // Vectored interrupt: trap seen SYNC_STAGES+1 edges after ext_int rises.
        tick();
        bus.mstatus = 32'h8;
        bus.mtvec   = 32'h301;
        plain(1'b1, 32'h200);
        tick();
        bus.ext_int = 1'b1;
        n   = 0;
        got = 1'b0;
        while (!got && n < 10) begin
            tick();
            n++;
            if (bus.is_trap) got = 1'b1;
        end
        check("int_latency",     n,               32'd3);
        check("int_mcause",      bus.mcause,      32'h8000000B);
        check("int_redirect_pc", bus.redirect_pc, 32'h32C);
        check("int_mepc",        bus.mepc,        32'h200);
        check("int_mtval",       bus.mtval,       32'h0);
        count_traps(8, pulses);
        check("int_held_no_retrap", pulses, 32'd0);

        // Edge while MIE=0 stays pending; bubbles do not take it.
        bus.ext_int = 1'b0;
        bus.mstatus = 32'h0;
        count_traps(4, pulses);
        bus.ext_int = 1'b1;
        count_traps(6, pulses);
        check("mie0_no_trap", pulses, 32'd0);
        plain(1'b0, 32'h2FC);
        bus.mstatus = 32'h8;
        count_traps(2, pulses);
        check("bubble_no_int", pulses, 32'd0);
        plain(1'b1, 32'h300);
        tick();
        check("pend_taken_trap",   {31'b0, bus.is_trap}, 32'd1);
        check("pend_taken_mcause", bus.mcause,           32'h8000000B);
        check("pend_taken_mepc",   bus.mepc,             32'h300);
        tick();
        bus.ext_int = 1'b0;

        // Reset in TRAP with an interrupt pending: pulses drop, pending is lost.
        bus.mstatus = 32'h0;
        bus.mtvec   = 32'h200;
        count_traps(4, pulses);
        bus.ext_int = 1'b1;
        count_traps(4, pulses);
        plain(1'b1, 32'h400);
        bus.exc_ecall = 1'b1;
        tick();
        check("rst_pre_is_trap", {31'b0, bus.is_trap}, 32'd1);
        #2;
        rst_n = 1'b0;
        bus.ext_int = 1'b0;
        #1;
        check("rst_is_trap",  {31'b0, bus.is_trap},  32'd0);
        check("rst_redirect", {31'b0, bus.redirect}, 32'd0);
        check("rst_flush",    {31'b0, bus.flush},    32'd0);
        check("rst_mcause",   bus.mcause,            32'h0);
        plain(1'b1, 32'h500);
        bus.mstatus = 32'h8;
        @(negedge clk);
        rst_n = 1'b1;
        count_traps(5, pulses);
        check("rst_pend_discarded", pulses, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
